idct_mac_sequencer: RTL and testbench
=====================================

// Module: idct_mac_sequencer
// PURPOSE
//   Address/control sequencer for the shared 8-tap IDCT MAC. It runs a full 2-D
//   IDCT as two 1-D passes: ROW (input buffer -> transpose buffer), then COL
//   (transpose buffer -> output buffer). It produces coefficient ROM and buffer
//   addresses, MAC enable/clear and result write strobes; pass selects the buffers.
// PARAMETERS
//   N        8  transform size; power of 2, >=2
//   MAC_LAT  2  cycles from the last mac_en tap to valid MAC result; 0 allowed
//   AW       6  address width, = 2*log2(N)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   level; sampled only in IDLE
//   stall      in   1   freeze sequencing (only with IDCT_SEQ_STALL_EN)
//   busy       out  1   high in MAC/DRAIN/WRITE
//   done       out  1   one-cycle pulse after both passes complete
//   pass       out  1   0=ROW pass, 1=COL pass
//   mac_en     out  1   MAC accumulates this cycle
//   mac_clr    out  1   first tap of an output; MAC loads instead of adds
//   rd_addr    out  AW  source buffer address = r*N+n
//   coef_addr  out  AW  coefficient ROM address = k*N+n
//   wr_en      out  1   write MAC result to destination buffer
//   wr_addr    out  AW  destination address = k*N+r (transposing write)
// BEHAVIOUR
//   - Counters: r (source row), k (output index), n (tap), d (drain), all
//     log2(N) bits except d; pass bit. Loop order: pass{r{k{n}}}.
//   - States: IDLE, MAC, DRAIN, WRITE, DONE. Outputs decode from registered
//     state/counters (Moore); no combinational path from inputs to outputs.
//   - IDLE: start=1 -> MAC with r=k=n=0, pass=0.
//   - MAC: mac_en=1, mac_clr=(n==0). n==N-1 -> DRAIN (d=0) if MAC_LAT>0,
//     otherwise -> WRITE.
//   - DRAIN: d counts to MAC_LAT-1, then -> WRITE. mac_en=0.
//   - WRITE: wr_en=1 for one cycle. Then advance k. On k wrap, advance r.
//     On r wrap with pass=0: pass=1 -> MAC. On r wrap with pass=1 -> DONE.
//     Otherwise -> MAC with n=0.
//   - DONE: done=1 for one cycle -> IDLE. start in DONE is ignored; if start is
//     still held, it is accepted in the following IDLE cycle.
//   - Per output: N+MAC_LAT+1 cycles. busy lasts exactly 2*N*N*(N+MAC_LAT+1)
//     cycles (1408 at defaults). done rises on the cycle busy falls.
//   - start while busy: ignored. Counters wrap modulo N and never overrun.
//   - rst asserted at any time: immediately IDLE, all counters 0, pass=0.
//     Every output = 0 while rst is high and after release, until start.
//   - Unused address outputs hold their last values; they are don't-care
//     when mac_en/wr_en are low.
// CONFIGURATION
//   IDCT_SEQ_STALL_EN defined:
//     - stall port exists. stall=1 holds state, counters and pass.
//     - mac_en and wr_en are forced 0 that cycle; addresses hold.
//     - done is deferred while stalled; busy stays high.
//     - busy duration grows by the number of stalled busy cycles.
//   IDCT_SEQ_STALL_EN undefined:
//     - no stall port; behaves as if stall=0.
// TESTING
//   1. rst=1 mid-pass (cycle 300 after start) -> next cycle busy=0,
//      mac_en=wr_en=done=0, pass=0. A later start restarts at rd_addr=0.
//   2. Defaults, 1-cycle start pulse -> busy high 1408 cycles, done 1 cycle,
//      exactly 128 wr_en pulses (64 with pass=0, then 64 with pass=1).
//   3. First output -> rd_addr 0..7 with coef_addr 0..7, mac_clr on the first
//      cycle only, 2 idle cycles, then wr_en with wr_addr=0. Second output ->
//      coef_addr 8..15, then wr_addr=8. Output r=1,k=0 -> wr_addr=1.
//   4. MAC_LAT=0 -> no DRAIN; wr_en follows the last tap directly;
//      busy=2*64*9=1152 cycles.
//   5. start held high continuously -> second run begins 1 cycle after done;
//      start pulses mid-run are ignored (wr_en count stays 128 per run).
//   6. STALL_EN: stall=1 for 5 cycles during MAC n=3 -> n holds at 3,
//      mac_en=0; sequence resumes at n=3; busy=1413 cycles.

Source files
------------

// File: rtl/idct_mac_sequencer_if.sv
// rtl/idct_mac_sequencer_if.sv - control/address bundle between the IDCT sequencer and the MAC datapath
// stall exists only when IDCT_SEQ_STALL_EN is defined.
interface idct_mac_sequencer_if #(
    parameter int AW = 6
);
    logic          start;
`ifdef IDCT_SEQ_STALL_EN
    logic          stall;
`endif
    logic          busy;
    logic          done;
    logic          pass;
    logic          mac_en;
    logic          mac_clr;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef_addr;
    logic [AW-1:0] wr_addr;

`ifdef IDCT_SEQ_STALL_EN
    modport master (
        input  start, stall,
        output busy, done, pass, mac_en, mac_clr, wr_en, rd_addr, coef_addr, wr_addr
    );
    modport slave (
        output start, stall,
        input  busy, done, pass, mac_en, mac_clr, wr_en, rd_addr, coef_addr, wr_addr
    );
`else
    modport master (
        input  start,
        output busy, done, pass, mac_en, mac_clr, wr_en, rd_addr, coef_addr, wr_addr
    );
    modport slave (
        output start,
        input  busy, done, pass, mac_en, mac_clr, wr_en, rd_addr, coef_addr, wr_addr
    );
`endif
endinterface

// File: rtl/idct_mac_sequencer.sv
// rtl/idct_mac_sequencer.sv - two-pass (ROW then COL) address/control sequencer for the shared 8-tap IDCT MAC
// Optional freeze input enabled by IDCT_SEQ_STALL_EN.
module idct_mac_sequencer #(
    parameter int N       = 8,
    parameter int MAC_LAT = 2,
    parameter int AW      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    idct_mac_sequencer_if.master  bus
);
    localparam int LW = $clog2(N);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [LW-1:0] N_LAST = LW'(N - 1);
    localparam logic [DW-1:0] D_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] r_q, r_d;
    logic [LW-1:0] k_q, k_d;
    logic [LW-1:0] n_q, n_d;
    logic [DW-1:0] d_q, d_d;
    logic          pass_q, pass_d;
    logic          stalled;

`ifdef IDCT_SEQ_STALL_EN
    assign stalled = bus.stall;
`else
    assign stalled = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            n_q     <= n_d;
            d_q     <= d_d;
            pass_q  <= pass_d;
        end
    end

    // Loop nest is pass{r{k{n}}}; n stays at N-1 through DRAIN/WRITE so read addresses hold.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        n_d     = n_q;
        d_d     = d_q;
        pass_d  = pass_q;
        if (!stalled) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_MAC;
                        r_d     = '0;
                        k_d     = '0;
                        n_d     = '0;
                        d_d     = '0;
                        pass_d  = 1'b0;
                    end
                end
                S_MAC: begin
                    if (n_q == N_LAST) begin
                        if (MAC_LAT > 0) begin
                            state_d = S_DRAIN;
                            d_d     = '0;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (d_q == D_LAST) begin
                        state_d = S_WRITE;
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    state_d = S_MAC;
                    n_d     = '0;
                    k_d     = k_q + 1'b1;
                    if (k_q == N_LAST) begin
                        r_d = r_q + 1'b1;
                        if (r_q == N_LAST) begin
                            if (!pass_q) begin
                                pass_d = 1'b1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign bus.done      = (state_q == S_DONE) && !stalled;
    assign bus.pass      = pass_q;
    assign bus.mac_en    = (state_q == S_MAC) && !stalled;
    assign bus.mac_clr   = (state_q == S_MAC) && !stalled && (n_q == '0);
    assign bus.wr_en     = (state_q == S_WRITE) && !stalled;
    // Write address swaps row/column so the second pass reads the transpose.
    assign bus.rd_addr   = AW'({r_q, n_q});
    assign bus.coef_addr = AW'({k_q, n_q});
    assign bus.wr_addr   = AW'({k_q, r_q});
endmodule

// File: tb/tb_idct_mac_sequencer.sv
// tb/tb_idct_mac_sequencer.sv - randomized self-checking bench for idct_mac_sequencer against a loop-nest model
module tb_idct_mac_sequencer;
    localparam int N   = 8;
    localparam int LAT = 2;
    localparam int AW  = 6;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    idct_mac_sequencer_if #(.AW(AW)) bus1 ();
    idct_mac_sequencer_if #(.AW(AW)) bus0 ();

    assign bus1.start = start;
    assign bus0.start = start;
`ifdef IDCT_SEQ_STALL_EN
    assign bus1.stall = 1'b0;
    assign bus0.stall = 1'b0;
`endif

    idct_mac_sequencer #(.N(N), .MAC_LAT(LAT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    idct_mac_sequencer #(.N(N), .MAC_LAT(0), .AW(AW)) dut_lat0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        bit busy;
        bit done;
        bit pass;
        bit mac_en;
        bit mac_clr;
        bit wr_en;
        int rd;
        int coef;
        int wr;
    } exp_t;

    exp_t tmpl[$];
    exp_t mq[$];
    exp_t cur;
    bit   zero_addr;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   runs1  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One full 2-D run, cycle by cycle, straight from the loop nest; final entry is the done cycle.
    task automatic build_run(input int lat);
        exp_t e;
        tmpl.delete();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++)
                for (int k = 0; k < N; k++) begin
                    for (int n = 0; n < N; n++) begin
                        e = '{busy: 1, done: 0, pass: (p != 0), mac_en: 1, mac_clr: (n == 0),
                              wr_en: 0, rd: r * N + n, coef: k * N + n, wr: 0};
                        tmpl.push_back(e);
                    end
                    for (int d = 0; d < lat; d++) begin
                        e = '{busy: 1, done: 0, pass: (p != 0), mac_en: 0, mac_clr: 0,
                              wr_en: 0, rd: 0, coef: 0, wr: 0};
                        tmpl.push_back(e);
                    end
                    e = '{busy: 1, done: 0, pass: (p != 0), mac_en: 0, mac_clr: 0,
                          wr_en: 1, rd: 0, coef: 0, wr: k * N + r};
                    tmpl.push_back(e);
                end
        e = '{busy: 0, done: 1, pass: 0, mac_en: 0, mac_clr: 0, wr_en: 0, rd: 0, coef: 0, wr: 0};
        tmpl.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            cur       = '{default: 0};
            zero_addr = 1'b1;
        end else begin
            if (!cur.busy && !cur.done && start) begin
                foreach (tmpl[i]) mq.push_back(tmpl[i]);
                zero_addr = 1'b0;
            end
            if (mq.size() > 0) cur = mq.pop_front();
            else               cur = '{default: 0};
        end
    end

    always @(negedge clk) begin
        chk("busy",    bus1.busy,    cur.busy);
        chk("done",    bus1.done,    cur.done);
        chk("mac_en",  bus1.mac_en,  cur.mac_en);
        chk("mac_clr", bus1.mac_clr, cur.mac_clr);
        chk("wr_en",   bus1.wr_en,   cur.wr_en);
        if (cur.busy || zero_addr)
            chk("pass", bus1.pass, cur.pass);
        if (cur.mac_en || zero_addr) begin
            chk("rd_addr",   bus1.rd_addr,   cur.rd);
            chk("coef_addr", bus1.coef_addr, cur.coef);
        end
        if (cur.wr_en || zero_addr)
            chk("wr_addr", bus1.wr_addr, cur.wr);
    end

    int bl1 = 0, wc1 = 0, wp1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            bl1 = 0; wc1 = 0; wp1 = 0;
        end else if (bus1.busy) begin
            bl1++;
            if (bus1.wr_en) begin
                wc1++;
                if (!bus1.pass) wp1++;
            end
        end else begin
            if (bl1 != 0) begin
                chk("busy_len", bl1, 1408);
                chk("wr_count", wc1, 128);
                chk("wr_count_row", wp1, 64);
                chk("done_at_busy_fall", bus1.done, 1);
                runs1++;
            end
            bl1 = 0; wc1 = 0; wp1 = 0;
        end
    end

    int  bl0 = 0, wc0 = 0;
    bit  prev_mac0 = 1'b0;
    logic [AW-1:0] prev_coef0 = '0;
    always @(negedge clk) begin
        if (rst) begin
            bl0 = 0; wc0 = 0;
        end else if (bus0.busy) begin
            bl0++;
            if (bus0.wr_en) begin
                wc0++;
                chk("lat0_wr_after_last_tap", {31'd0, prev_mac0 && (prev_coef0[2:0] == 3'd7)}, 1);
            end
        end else begin
            if (bl0 != 0) begin
                chk("lat0_busy_len", bl0, 1152);
                chk("lat0_wr_count", wc0, 128);
                chk("lat0_done_at_busy_fall", bus0.done, 1);
            end
            bl0 = 0; wc0 = 0;
        end
        prev_mac0  = bus0.mac_en;
        prev_coef0 = bus0.coef_addr;
    end

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus1.done) break;
        end
        chk("done_within_budget", {31'd0, i < budget}, 1);
    endtask

    task automatic do_run();
        repeat ($urandom_range(1, 6)) @(negedge clk);
        start = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(50, 300)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(3000);
    endtask

    initial begin
        int wcount;
        cur       = '{default: 0};
        zero_addr = 1'b1;
        build_run(LAT);

        chk("model_len", tmpl.size(), 1409);
        chk("model_first_clr", {31'd0, tmpl[0].mac_clr}, 1);
        chk("model_second_clr", {31'd0, tmpl[1].mac_clr}, 0);
        chk("model_drain_idle", {31'd0, tmpl[8].mac_en}, 0);
        chk("model_wr0_en", {31'd0, tmpl[10].wr_en}, 1);
        chk("model_wr0_addr", tmpl[10].wr, 0);
        chk("model_out1_coef", tmpl[11].coef, 8);
        chk("model_out1_wr", tmpl[21].wr, 8);
        chk("model_r1k0_wr", tmpl[98].wr, 1);
        wcount = 0;
        foreach (tmpl[i]) if (tmpl[i].wr_en) wcount++;
        chk("model_wr_total", wcount, 128);

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);

        do_run();
        do_run();

        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_mac_en", bus1.mac_en, 0);
        chk("rst_wr_en", bus1.wr_en, 0);
        chk("rst_done", bus1.done, 0);
        chk("rst_pass", bus1.pass, 0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        do_run();

        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_done(3000);
        wait_done(3000);
        start = 1'b0;
        repeat (5) @(negedge clk);

        do_run();
        repeat (5) @(negedge clk);
        chk("runs_completed", runs1, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
